edge_pulse_generator: RTL and testbench



---
 rtl/edge_pulse_generator.sv | 130 +++++++++++++
 tb/tb_edge_pulse_generator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_generator.sv
// Turns single-cycle requests into timed assert/recover windows on a glitch-free registered level.
// Requests that arrive while a window is running are queued in a saturating counter and replayed in order.
module edge_pulse_generator #(
    parameter bit          EDGE_TYPE       = 1'b1,
    parameter int unsigned ASSERT_CYCLES   = 4,
    parameter int unsigned DEASSERT_CYCLES = 4,
    parameter int unsigned PEND_WIDTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_qual_n,
    input  logic                  pulse_in,
    input  logic                  enable,
    output logic                  signal_out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  edge_done,
    output logic                  overflow
);

    localparam int unsigned MAX_CYC = (ASSERT_CYCLES > DEASSERT_CYCLES) ? ASSERT_CYCLES : DEASSERT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]      ASSERT_LOAD   = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DEASSERT_LOAD = CNT_W'(DEASSERT_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX      = '1;
    localparam logic                  ASSERT_LEVEL  = EDGE_TYPE;
    localparam logic                  IDLE_LEVEL    = ~EDGE_TYPE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PEND_WIDTH-1:0]   pending_d;
    logic                    signal_d;
    logic                    edge_done_d;
    logic                    overflow_d;
    logic                    busy_d;
    logic                    decide;
    logic                    take;
    logic                    consume;
    logic                    bypass;
    logic                    inc;

    // State, window counter, queue and all registered outputs
    always_ff @(posedge clk or negedge reset_qual_n) begin
        if (!reset_qual_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending    <= '0;
            signal_out <= IDLE_LEVEL;
            edge_done  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending    <= pending_d;
            signal_out <= signal_d;
            edge_done  <= edge_done_d;
            overflow   <= overflow_d;
            busy       <= busy_d;
        end
    end

    // Next-state, window timing and queue bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_done_d = 1'b0;
        overflow_d  = 1'b0;
        pending_d   = pending;
        decide      = 1'b0;

        case (state_q)
            IDLE: decide = 1'b1;
            ASSERT: begin
                if (cnt_q == '0) begin
                    state_d     = RECOVER;
                    cnt_d       = DEASSERT_LOAD;
                    edge_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    decide = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // enable only matters where a new window could begin
        take = decide && enable && ((pending != '0) || pulse_in);
        if (take) begin
            state_d = ASSERT;
            cnt_d   = ASSERT_LOAD;
        end else if (decide) begin
            state_d = IDLE;
        end

        // Queued entries go first; a pulse with an empty queue starts directly
        consume = take && (pending != '0);
        bypass  = take && (pending == '0);
        inc     = pulse_in && !bypass;

        if (inc && !consume) begin
            if (pending == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending + PEND_WIDTH'(1);
            end
        end else if (!inc && consume) begin
            pending_d = pending - PEND_WIDTH'(1);
        end

        signal_d = (state_d == ASSERT) ? ASSERT_LEVEL : IDLE_LEVEL;
        busy_d   = (state_d != IDLE) || (pending_d != '0);
    end

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Directed bench for edge_pulse_generator: rising-polarity table vectors plus
// falling-polarity overflow and mid-window reset sequences.
module tb_edge_pulse_generator;

    typedef struct {
        logic       pulse;
        logic       en;
        logic       sig;
        logic       edge_d;
        logic       busy;
        logic [3:0] pend;
    } vec_t;

    logic       clk;
    logic       rst_r_n, pulse_r, en_r;
    logic       sig_r, busy_r, edge_r, ovf_r;
    logic [3:0] pend_r;

    logic       rst_f_n, pulse_f, en_f;
    logic       sig_f, busy_f, edge_f, ovf_f;
    logic [1:0] pend_f;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    edge_pulse_generator u_rise (
        .clk          (clk),
        .reset_qual_n (rst_r_n),
        .pulse_in     (pulse_r),
        .enable       (en_r),
        .signal_out   (sig_r),
        .busy         (busy_r),
        .pending      (pend_r),
        .edge_done    (edge_r),
        .overflow     (ovf_r)
    );

    edge_pulse_generator #(
        .EDGE_TYPE       (1'b0),
        .ASSERT_CYCLES   (4),
        .DEASSERT_CYCLES (4),
        .PEND_WIDTH      (2)
    ) u_fall (
        .clk          (clk),
        .reset_qual_n (rst_f_n),
        .pulse_in     (pulse_f),
        .enable       (en_f),
        .signal_out   (sig_f),
        .busy         (busy_f),
        .pending      (pend_f),
        .edge_done    (edge_f),
        .overflow     (ovf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic en, input logic sig, input logic ed,
                       input logic bz, input logic [3:0] pd, input int n);
        vec_t v;
        v.pulse = p; v.en = en; v.sig = sig; v.edge_d = ed; v.busy = bz; v.pend = pd;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int windows;
        int edge_seen;
        logic prev_sig;

        rst_r_n = 1'b0; pulse_r = 1'b0; en_r = 1'b1;
        rst_f_n = 1'b0; pulse_f = 1'b0; en_f = 1'b1;

        // Single request
        add(1,1, 0,0,0,0, 1);
        add(0,1, 1,0,1,0, 4);
        add(0,1, 0,1,1,0, 1);
        add(0,1, 0,0,1,0, 3);
        add(0,1, 0,0,0,0, 2);
        // Queued burst of three
        add(1,1, 0,0,0,0, 1);
        add(1,1, 1,0,1,0, 1);
        add(1,1, 1,0,1,1, 1);
        add(0,1, 1,0,1,2, 2);
        add(0,1, 0,1,1,2, 1);
        add(0,1, 0,0,1,2, 3);
        add(0,1, 1,0,1,1, 4);
        add(0,1, 0,1,1,1, 1);
        add(0,1, 0,0,1,1, 3);
        add(0,1, 1,0,1,0, 4);
        add(0,1, 0,1,1,0, 1);
        add(0,1, 0,0,1,0, 3);
        add(0,1, 0,0,0,0, 1);
        // Enable gating, enable raised at cycle 20
        add(1,0, 0,0,0,0, 1);
        add(1,0, 0,0,1,1, 1);
        add(0,0, 0,0,1,2, 18);
        add(0,1, 0,0,1,2, 1);
        add(0,1, 1,0,1,1, 4);
        add(0,1, 0,1,1,1, 1);
        add(0,1, 0,0,1,1, 3);
        add(0,1, 1,0,1,0, 4);
        add(0,1, 0,1,1,0, 1);
        add(0,1, 0,0,1,0, 3);
        add(0,1, 0,0,0,0, 1);
        // Pulse in final recover cycle with one entry queued
        add(1,1, 0,0,0,0, 1);
        add(1,1, 1,0,1,0, 1);
        add(0,1, 1,0,1,1, 3);
        add(0,1, 0,1,1,1, 1);
        add(0,1, 0,0,1,1, 2);
        add(1,1, 0,0,1,1, 1);
        add(0,1, 1,0,1,1, 4);
        add(0,1, 0,1,1,1, 1);
        add(0,1, 0,0,1,1, 3);
        add(0,1, 1,0,1,0, 4);
        add(0,1, 0,1,1,0, 1);
        add(0,1, 0,0,1,0, 3);
        add(0,1, 0,0,0,0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset rise sig", sig_r, 0);
        check("reset rise busy", busy_r, 0);
        check("reset rise pend", pend_r, 0);
        check("reset rise edge", edge_r, 0);
        check("reset rise ovf", ovf_r, 0);
        check("reset fall sig", sig_f, 1);
        check("reset fall pend", pend_f, 0);
        check("reset fall busy", busy_f, 0);
        rst_r_n = 1'b1;
        rst_f_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            pulse_r = vecs[i].pulse;
            en_r    = vecs[i].en;
            check($sformatf("vec%0d sig", i),  sig_r,  vecs[i].sig);
            check($sformatf("vec%0d edge", i), edge_r, vecs[i].edge_d);
            check($sformatf("vec%0d busy", i), busy_r, vecs[i].busy);
            check($sformatf("vec%0d pend", i), pend_r, vecs[i].pend);
            check($sformatf("vec%0d ovf", i),  ovf_r,  0);
            next_cycle();
        end
        pulse_r = 1'b0;

        // Overflow on the 2-bit queue: six back-to-back requests
        windows  = 0;
        prev_sig = sig_f;
        for (int c = 0; c <= 40; c++) begin
            pulse_f = (c < 6);
            if (c == 4) check("ovf pend sat", pend_f, 3);
            if (c >= 4 && c <= 7) check($sformatf("ovf pulse c%0d", c), ovf_f, (c == 5 || c == 6) ? 1 : 0);
            if (prev_sig && !sig_f) windows++;
            prev_sig = sig_f;
            next_cycle();
        end
        pulse_f = 1'b0;
        check("ovf windows", windows, 4);
        check("ovf busy end", busy_f, 0);
        check("ovf pend end", pend_f, 0);

        // Reset in the second low cycle of a falling window
        edge_seen = 0;
        pulse_f = 1'b1;
        next_cycle();
        next_cycle();
        pulse_f = 1'b0;
        check("rst pre sig", sig_f, 0);
        check("rst pre pend", pend_f, 1);
        rst_f_n = 1'b0;
        #1;
        check("rst async sig", sig_f, 1);
        check("rst async pend", pend_f, 0);
        check("rst async busy", busy_f, 0);
        next_cycle();
        rst_f_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (edge_f) edge_seen++;
            if (!sig_f) edge_seen++;
            next_cycle();
        end
        check("rst no edge_done", edge_seen, 0);
        check("rst idle pend", pend_f, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
